asm_unit: RTL and testbench



---
 rtl/bnn_pkg.sv | 25 ++
 rtl/asm_acc.sv | 41 ++++
 rtl/asm_unit.sv | 58 +++++
 tb/tb_asm_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared sizing helpers and operation encoding for the binary-network neuron datapath.
package bnn_pkg;

  // The accumulator must hold the wider of pixel/threshold plus guard bits for the term count.
  function automatic int acc_w(input int img_w, input int bn_w, input int res_w);
    return ((img_w > bn_w) ? img_w : bn_w) + res_w;
  endfunction

  function automatic int max_terms(input int res_w);
    return (1 << res_w) - 1;
  endfunction

  localparam int IMG_WIDTH_DEF    = 16;
  localparam int BN_WIDTH_DEF     = 16;
  localparam int RESULT_WIDTH_DEF = 6;
  localparam int MAX_TERMS        = max_terms(RESULT_WIDTH_DEF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_CALC,
    S_SEND
  } op_t;

endpackage

// File: rtl/asm_acc.sv
// Signed add/subtract accumulator with a saturating term counter.
import bnn_pkg::*;

module asm_acc #(
  parameter int data_width = 16,
  parameter int acc_width  = 22,
  parameter int cnt_width  = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  input  logic                        add,
  input  logic signed [data_width-1:0] data,
  output logic signed [acc_width-1:0]  acc
);

  localparam logic [cnt_width-1:0] CNT_MAX = cnt_width'(max_terms(cnt_width));

  logic [cnt_width-1:0]        cnt;
  logic signed [acc_width-1:0] data_ext;
  logic signed [acc_width-1:0] term;

  // Widening before negation keeps -(most negative pixel) exact.
  assign data_ext = {{(acc_width-data_width){data[data_width-1]}}, data};
  assign term     = add ? data_ext : -data_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
    end else if (en && (cnt < CNT_MAX)) begin
      acc <= acc + term;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/asm_unit.sv
// Accumulate-sign-multiply neuron: sums +/-pixel per binary weight and binarises against a threshold.
import bnn_pkg::*;

module asm_unit #(
  parameter int img_width    = IMG_WIDTH_DEF,
  parameter int bn_width     = BN_WIDTH_DEF,
  parameter int result_width = RESULT_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       asm_send,
  input  logic                       asm_reception,
  input  logic                       calculate_en,
  input  logic                       data_weights,
  input  logic signed [img_width-1:0] data_pix,
  input  logic signed [bn_width-1:0]  data_bn,
  output logic                       data_out
);

  localparam int ACC_W = acc_w(img_width, bn_width, result_width);

  op_t                     op;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] thr;

  // One action per edge; lower-priority strobes are simply dropped.
  always_comb begin
    op = S_IDLE;
    if (asm_reception)     op = S_RECV;
    else if (calculate_en) op = S_CALC;
    else if (asm_send)     op = S_SEND;
  end

  asm_acc #(
    .data_width(img_width),
    .acc_width (ACC_W),
    .cnt_width (result_width)
  ) u_acc (
    .clk (clk),
    .rst (rst),
    .clr (op == S_RECV),
    .en  (op == S_CALC),
    .add (data_weights),
    .data(data_pix),
    .acc (acc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      thr      <= '0;
      data_out <= 1'b0;
    end else begin
      if (op == S_RECV) thr <= {{(ACC_W-bn_width){data_bn[bn_width-1]}}, data_bn};
      if (op == S_SEND) data_out <= (acc >= thr);
    end
  end

endmodule

// File: tb/tb_asm_unit.sv
// Self-checking bench for asm_unit: directed table, corner sequences, and randomized model comparison.
module tb_asm_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        asm_send;
  logic        asm_reception;
  logic        calculate_en;
  logic        data_weights;
  logic [15:0] data_pix;
  logic [15:0] data_bn;
  logic        data_out;

  int checks = 0;
  int errors = 0;

  longint m_acc;
  longint m_thr;
  int     m_cnt;
  bit     m_out;

  typedef struct packed {
    logic [15:0]       bn;
    logic [2:0]        n;
    logic [3:0][15:0]  pix;
    logic [3:0]        w;
    logic              exp_out;
    logic signed [31:0] exp_acc;
  } vec_t;

  vec_t vecs[8];

  asm_unit dut (
    .clk          (clk),
    .rst          (rst),
    .asm_send     (asm_send),
    .asm_reception(asm_reception),
    .calculate_en (calculate_en),
    .data_weights (data_weights),
    .data_pix     (data_pix),
    .data_bn      (data_bn),
    .data_out     (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic longint sx16(input logic [15:0] v);
    return longint'($signed(v));
  endfunction

  // Behavioural reference: apply the priority rules to one clock edge.
  task automatic model_edge(input bit rec, input bit calc, input bit send,
                            input bit w, input logic [15:0] pix, input logic [15:0] bn);
    if (rec) begin
      m_thr = sx16(bn);
      m_acc = 0;
      m_cnt = 0;
    end else if (calc) begin
      if (m_cnt < 63) begin
        m_acc = w ? m_acc + sx16(pix) : m_acc - sx16(pix);
        m_cnt++;
      end
    end else if (send) begin
      m_out = (m_acc >= m_thr);
    end
  endtask

  task automatic cyc(input bit rec, input bit calc, input bit send,
                     input bit w, input logic [15:0] pix, input logic [15:0] bn);
    asm_reception = rec;
    calculate_en  = calc;
    asm_send      = send;
    data_weights  = w;
    data_pix      = pix;
    data_bn       = bn;
    @(posedge clk);
    model_edge(rec, calc, send, w, pix, bn);
    #1;
    asm_reception = 1'b0;
    calculate_en  = 1'b0;
    asm_send      = 1'b0;
  endtask

  task automatic t_recv(input logic [15:0] bn);
    cyc(1, 0, 0, 0, 16'h0, bn);
  endtask
  task automatic t_calc(input logic [15:0] pix, input bit w);
    cyc(0, 1, 0, w, pix, 16'h0);
  endtask
  task automatic t_send();
    cyc(0, 0, 1, 0, 16'h0, 16'h0);
  endtask
  task automatic t_idle();
    cyc(0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  function automatic longint dut_acc();
    return longint'($signed(dut.acc));
  endfunction

  initial begin
    rst = 1'b0;
    asm_send = 0; asm_reception = 0; calculate_en = 0;
    data_weights = 0; data_pix = '0; data_bn = '0;
    m_acc = 0; m_thr = 0; m_cnt = 0; m_out = 0;

    vecs[0] = '{bn:16'd10,   n:3'd3, pix:{16'd0, 16'd2, 16'd3, 16'd5},    w:4'b0011, exp_out:1'b0, exp_acc:6};
    vecs[1] = '{bn:16'd6,    n:3'd3, pix:{16'd0, 16'd2, 16'd3, 16'd5},    w:4'b0011, exp_out:1'b1, exp_acc:6};
    vecs[2] = '{bn:16'hFFFB, n:3'd2, pix:{16'd0, 16'd0, 16'd4, 16'd4},    w:4'b0000, exp_out:1'b0, exp_acc:-8};
    vecs[3] = '{bn:16'hFFFB, n:3'd3, pix:{16'd0, 16'd3, 16'd4, 16'd4},    w:4'b0100, exp_out:1'b1, exp_acc:-5};
    vecs[4] = '{bn:16'h7FFF, n:3'd1, pix:{16'd0, 16'd0, 16'd0, 16'h8000}, w:4'b0000, exp_out:1'b1, exp_acc:32768};
    vecs[5] = '{bn:16'h8000, n:3'd1, pix:{16'd0, 16'd0, 16'd0, 16'h8000}, w:4'b0001, exp_out:1'b1, exp_acc:-32768};
    vecs[6] = '{bn:16'h8000, n:3'd2, pix:{16'd0, 16'd0, 16'd1, 16'h8000}, w:4'b0001, exp_out:1'b0, exp_acc:-32769};
    vecs[7] = '{bn:16'h0000, n:3'd0, pix:'0,                              w:4'b0000, exp_out:1'b1, exp_acc:0};

    repeat (3) @(posedge clk);
    #1;
    check("reset_out", data_out, 0);
    rst = 1'b1;
    t_idle();

    // Asynchronous reset mid-accumulation with data_out high and acc nonzero.
    t_recv(16'd0);
    t_calc(16'd5, 1);
    t_send();
    check("pre_reset_out", data_out, 1);
    t_calc(16'd3, 1);
    check("pre_reset_acc", dut_acc(), 8);
    #2 rst = 1'b0;
    m_acc = 0; m_thr = 0; m_cnt = 0; m_out = 0;
    #1;
    check("async_reset_out", data_out, 0);
    check("async_reset_acc", dut_acc(), 0);
    @(negedge clk);
    rst = 1'b1;
    t_send();
    check("post_reset_send", data_out, 1);

    for (int i = 0; i < 8; i++) begin
      t_recv(vecs[i].bn);
      for (int k = 0; k < int'(vecs[i].n); k++) t_calc(vecs[i].pix[k], vecs[i].w[k]);
      check($sformatf("vec%0d_acc", i), dut_acc(), longint'(vecs[i].exp_acc));
      t_send();
      check($sformatf("vec%0d_out", i), data_out, vecs[i].exp_out);
      t_send();
      check($sformatf("vec%0d_resend", i), data_out, vecs[i].exp_out);
    end

    // Saturation at 63 terms with extreme positive pixel.
    t_recv(16'h7FFF);
    for (int k = 0; k < 70; k++) t_calc(16'h7FFF, 1);
    check("sat_acc", dut_acc(), 63 * 32767);
    check("sat_cnt", longint'(dut.u_acc.cnt), 63);
    t_send();
    check("sat_out", data_out, 1);

    // Dropped terms must be observable at the output too.
    t_recv(16'hFFC1);
    for (int k = 0; k < 63; k++) t_calc(16'd1, 0);
    for (int k = 0; k < 10; k++) t_calc(16'd100, 1);
    t_send();
    check("sat_drop_eq", data_out, 1);
    t_recv(16'hFFC2);
    for (int k = 0; k < 63; k++) t_calc(16'd1, 0);
    for (int k = 0; k < 10; k++) t_calc(16'd100, 1);
    t_send();
    check("sat_drop_gt", data_out, 0);

    // Priority: reception wins over calc and send.
    t_recv(16'd0);
    t_send();
    check("prio_setup", data_out, 1);
    t_calc(16'd7, 1);
    cyc(1, 1, 1, 1, 16'd9, 16'd100);
    check("prio_all_acc", dut_acc(), 0);
    check("prio_all_cnt", longint'(dut.u_acc.cnt), 0);
    check("prio_all_out", data_out, 1);
    cyc(0, 1, 1, 1, 16'd5, 16'd0);
    check("prio_calc_acc", dut_acc(), 5);
    check("prio_calc_out", data_out, 1);
    t_send();
    check("prio_send_out", data_out, 0);

    // Hold: data_out only changes on a send.
    t_recv(16'd0);
    t_send();
    for (int k = 0; k < 20; k++) begin
      t_idle();
      if (data_out !== 1'b1) check("hold_idle", data_out, 1);
    end
    check("hold_idle_end", data_out, 1);
    t_calc(16'd9, 0);
    check("hold_after_calc", data_out, 1);
    t_send();
    check("hold_next_send", data_out, 0);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      automatic int r = $urandom_range(0, 99);
      automatic bit rec  = (r < 4);
      automatic bit calc = ($urandom_range(0, 99) < 65);
      automatic bit send = ($urandom_range(0, 99) < 30);
      automatic logic [15:0] pix;
      automatic logic [15:0] bn;
      case ($urandom_range(0, 7))
        0:       pix = 16'h8000;
        1:       pix = 16'h7FFF;
        2:       pix = 16'(($urandom_range(0, 40)) - 20);
        default: pix = 16'($urandom);
      endcase
      bn = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 2000) - 1000);
      cyc(rec, calc, send, 1'($urandom), pix, bn);
      if (data_out !== m_out) check($sformatf("rand_out_%0d", c), data_out, m_out);
      if (dut_acc() != m_acc) check($sformatf("rand_acc_%0d", c), dut_acc(), m_acc);
      if ((c % 100) == 99) begin
        check($sformatf("rand_out_s%0d", c), data_out, m_out);
        check($sformatf("rand_acc_s%0d", c), dut_acc(), m_acc);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
